// File: rtl/tmr_fault_monitor.sv
// Triple-modular-redundancy voter with per-lane fault accounting.
// Votes three replica words, tracks disagreeing lanes and raises irq.
module tmr_fault_monitor #(
  parameter int BW_DATA           = 8,
  parameter int BW_COUNT          = 8,
  parameter int PERSIST_THRESHOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  sample_valid,
  input  logic [3*BW_DATA-1:0]  replica_in,
  output logic                  voted_valid,
  output logic [BW_DATA-1:0]    voted_data,
  output logic [2:0]            mismatch_lane,
  output logic                  multi_fault,
  output logic [3*BW_COUNT-1:0] err_count,
  output logic [2:0]            lane_failed,
  output logic                  irq,
  input  logic                  irq_clear,
  input  logic                  stat_clear
);

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_SUSPECT = 2'd1;
  localparam logic [1:0] ST_FAILED  = 2'd2;
  localparam logic [7:0] THR        = 8'(PERSIST_THRESHOLD);

  logic                accept;
  logic [BW_DATA-1:0]  lane [3];
  logic [BW_DATA-1:0]  maj;
  logic [2:0]          m;
  logic                mf;

  logic [1:0]          st_q  [3];
  logic [1:0]          st_d  [3];
  logic [7:0]          run_q [3];
  logic [7:0]          run_d [3];
  logic [BW_COUNT-1:0] cnt_q [3];
  logic [BW_COUNT-1:0] cnt_d [3];
  logic [2:0]          enter_failed;
  logic                irq_set;

  assign accept = enable & sample_valid;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      lane[k] = replica_in[BW_DATA*k +: BW_DATA];
    end
    maj = (lane[0] & lane[1]) |
          (lane[0] & lane[2]) |
          (lane[1] & lane[2]);
    for (int k = 0; k < 3; k++) begin
      m[k] = |(lane[k] ^ maj);
    end
    mf = ({1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]}) >= 2'd2;
  end

  // Per-lane persistence tracking; stat_clear overrides any sample update
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      st_d[k]  = st_q[k];
      run_d[k] = run_q[k];
      cnt_d[k] = cnt_q[k];
      if (accept && m[k] && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + BW_COUNT'(1);
      end
      if (accept) begin
        case (st_q[k])
          ST_OK: begin
            if (m[k]) begin
              run_d[k] = 8'd1;
              st_d[k]  = (THR == 8'd1) ? ST_FAILED : ST_SUSPECT;
            end
          end
          ST_SUSPECT: begin
            if (m[k]) begin
              run_d[k] = run_q[k] + 8'd1;
              if (run_q[k] + 8'd1 == THR) st_d[k] = ST_FAILED;
            end else begin
              run_d[k] = 8'd0;
              st_d[k]  = ST_OK;
            end
          end
          default: ;
        endcase
      end
      if (stat_clear) begin
        st_d[k]  = ST_OK;
        run_d[k] = 8'd0;
        cnt_d[k] = '0;
      end
      enter_failed[k] = (st_d[k] == ST_FAILED) && (st_q[k] != ST_FAILED);
    end
  end

  assign irq_set = (accept && (|m)) || (|enter_failed);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voted_valid   <= 1'b0;
      voted_data    <= '0;
      mismatch_lane <= '0;
      multi_fault   <= 1'b0;
      irq           <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        st_q[k]  <= ST_OK;
        run_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      voted_valid <= accept;
      if (accept) begin
        voted_data    <= maj;
        mismatch_lane <= m;
        multi_fault   <= mf;
      end
      if (irq_set)        irq <= 1'b1;
      else if (irq_clear) irq <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        st_q[k]  <= st_d[k];
        run_q[k] <= run_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      err_count[BW_COUNT*k +: BW_COUNT] = cnt_q[k];
      lane_failed[k] = (st_q[k] == ST_FAILED);
    end
  end

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed and randomized bench for tmr_fault_monitor.
// Reference model tracks lanes with plain counts and run lengths.
module tb_tmr_fault_monitor;

  localparam int BWD = 8;
  localparam int BWC = 4;
  localparam int THR = 4;
  localparam int CMAX = (1 << BWC) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            sample_valid;
  logic [3*BWD-1:0] replica_in;
  logic            voted_valid;
  logic [BWD-1:0]  voted_data;
  logic [2:0]      mismatch_lane;
  logic            multi_fault;
  logic [3*BWC-1:0] err_count;
  logic [2:0]      lane_failed;
  logic            irq;
  logic            irq_clear;
  logic            stat_clear;

  int tests = 0;
  int failed = 0;

  int       cnt [3];
  int       run [3];
  bit       fl  [3];
  bit       e_vv;
  bit [7:0] e_vd;
  bit [2:0] e_ml;
  bit       e_mf;
  bit       e_irq;

  tmr_fault_monitor #(
    .BW_DATA(BWD), .BW_COUNT(BWC), .PERSIST_THRESHOLD(THR)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sample_valid(sample_valid), .replica_in(replica_in),
    .voted_valid(voted_valid), .voted_data(voted_data),
    .mismatch_lane(mismatch_lane), .multi_fault(multi_fault),
    .err_count(err_count), .lane_failed(lane_failed),
    .irq(irq), .irq_clear(irq_clear), .stat_clear(stat_clear)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rep(input logic [7:0] a, b, c);
    return {c, b, a};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0; run[k] = 0; fl[k] = 0;
    end
    e_vv = 0; e_vd = 0; e_ml = 0; e_mf = 0; e_irq = 0;
  endtask

  task automatic model_edge(input bit en, sv, input logic [23:0] d,
                            input bit ic, sc);
    bit acc;
    bit [7:0] mj;
    bit [2:0] mm;
    int ones;
    acc = en && sv;
    mm = 0;
    if (acc) begin
      for (int b = 0; b < 8; b++) begin
        ones = int'(d[b]) + int'(d[8+b]) + int'(d[16+b]);
        mj[b] = (ones >= 2);
      end
      for (int k = 0; k < 3; k++) mm[k] = (d[8*k +: 8] != mj);
      e_vd = mj;
      e_ml = mm;
      e_mf = (int'(mm[0]) + int'(mm[1]) + int'(mm[2])) >= 2;
    end
    e_vv = acc;
    if (acc && mm != 0) e_irq = 1;
    else if (ic) e_irq = 0;
    if (sc) begin
      for (int k = 0; k < 3; k++) begin
        cnt[k] = 0; run[k] = 0; fl[k] = 0;
      end
    end else if (acc) begin
      for (int k = 0; k < 3; k++) begin
        if (mm[k] && cnt[k] < CMAX) cnt[k]++;
        if (!fl[k]) begin
          if (mm[k]) begin
            run[k]++;
            if (run[k] >= THR) fl[k] = 1;
          end else begin
            run[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".vv"}, 32'(voted_valid), 32'(e_vv));
    chk({tag, ".vd"}, 32'(voted_data), 32'(e_vd));
    chk({tag, ".ml"}, 32'(mismatch_lane), 32'(e_ml));
    chk({tag, ".mf"}, 32'(multi_fault), 32'(e_mf));
    chk({tag, ".err"}, 32'(err_count),
        32'({4'(cnt[2]), 4'(cnt[1]), 4'(cnt[0])}));
    chk({tag, ".lf"}, 32'(lane_failed), 32'({fl[2], fl[1], fl[0]}));
    chk({tag, ".irq"}, 32'(irq), 32'(e_irq));
  endtask

  task automatic step(input string tag, input bit en, sv,
                      input logic [23:0] d, input bit ic, sc);
    enable = en; sample_valid = sv; replica_in = d;
    irq_clear = ic; stat_clear = sc;
    @(posedge clk);
    model_edge(en, sv, d, ic, sc);
    #1;
    enable = 0; sample_valid = 0; irq_clear = 0; stat_clear = 0;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] l [3];
    logic [7:0] base;
    bit en, sv, ic, sc;
    rst = 1; enable = 0; sample_valid = 0; replica_in = '0;
    irq_clear = 0; stat_clear = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 10; i++) step("clean", 1, 1, rep(8'hA5, 8'hA5, 8'hA5), 0, 0);
    chk("clean.vd_direct", 32'(voted_data), 32'h A5);

    for (int i = 0; i < 3; i++) step("f2a", 1, 1, rep(8'hA5, 8'hA5, 8'hA4), 0, 0);
    step("f2gap", 1, 1, rep(8'hA5, 8'hA5, 8'hA5), 0, 0);
    for (int i = 0; i < 3; i++) step("f2b", 1, 1, rep(8'hA5, 8'hA5, 8'hA4), 0, 0);
    chk("f2.err2_direct", 32'(err_count[11:8]), 32'd6);
    chk("f2.lf_direct", 32'(lane_failed), 32'd0);
    step("f2.idle", 0, 0, 'x, 0, 0);
    chk("f2.irq_hold", 32'(irq), 32'd1);
    step("f2.iclr", 0, 0, 'x, 1, 0);
    chk("f2.irq_clr", 32'(irq), 32'd0);

    for (int i = 0; i < 4; i++) begin
      step("pers", 1, 1, rep(8'h3C ^ 8'h40, 8'h3C, 8'h3C), 0, 0);
      if (i < 3) begin
        step("pers.idle", 1, 0, 'x, 0, 0);
        step("pers.dis", 0, 1, 'x, 1, 0);
        chk("pers.lf0_low", 32'(lane_failed[0]), 32'd0);
      end
    end
    chk("pers.lf0_set", 32'(lane_failed[0]), 32'd1);
    chk("pers.irq", 32'(irq), 32'd1);

    step("sclr", 0, 0, 'x, 0, 1);
    for (int i = 0; i < 20; i++)
      step("multi", 1, 1, rep(8'h5A ^ 8'h01, 8'h5A ^ 8'h08, 8'h5A), 0, 0);
    chk("multi.ml", 32'(mismatch_lane), 32'b011);
    chk("multi.mf", 32'(multi_fault), 32'd1);
    chk("multi.err", 32'(err_count), 32'h0FF);

    step("sim.iclr", 1, 1, rep(8'h11, 8'h11, 8'h91), 1, 0);
    chk("sim.irq_stays", 32'(irq), 32'd1);
    step("sim.sclr", 1, 1, rep(8'h11, 8'h10, 8'h11), 0, 1);
    chk("sim.sclr_err", 32'(err_count), 32'd0);
    chk("sim.sclr_ml", 32'(mismatch_lane), 32'b010);

    for (int i = 0; i < 400; i++) begin
      base = 8'($urandom);
      for (int k = 0; k < 3; k++) l[k] = base;
      case ($urandom_range(0, 5))
        3: begin
          int k;
          k = $urandom_range(0, 2);
          l[k] = base ^ 8'($urandom_range(1, 255));
        end
        4: begin
          l[0] = base ^ 8'h81;
          l[2] = base ^ 8'h18;
        end
        5: l[0] = base ^ 8'h20;
        default: ;
      endcase
      en = ($urandom_range(0, 7) != 0);
      sv = ($urandom_range(0, 7) != 0);
      ic = ($urandom_range(0, 9) == 0);
      sc = ($urandom_range(0, 39) == 0);
      step("rand", en, sv, rep(l[0], l[1], l[2]), ic, sc);
    end

    step("rm.sclr", 0, 0, 'x, 0, 1);
    for (int i = 0; i < 4; i++) step("rm.f1", 1, 1, rep(8'h77, 8'h67, 8'h77), 0, 0);
    chk("rm.lf1", 32'(lane_failed), 32'b010);
    #3;
    rst = 1;
    model_reset();
    #1;
    check_all("rm.async");
    @(negedge clk);
    rst = 0;
    step("rm.after", 1, 1, rep(8'h77, 8'h67, 8'h77), 0, 0);
    chk("rm.lf_ok", 32'(lane_failed), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/tmr_fault_monitor.md
Name: tmr_fault_monitor

Overview:
- Sits directly downstream of the triple-redundant data path. Consumes the three replica words, produces a registered bitwise-majority result, and identifies which lane disagrees.
- Keeps per-lane saturating error counters and a per-lane persistence state machine that promotes repeated faults to a sticky lane-failed status.
- Raises a level interrupt toward the fault manager.

Parameters:
BW_DATA, 8, width of one replica word
BW_COUNT, 8, width of each per-lane error counter
PERSIST_THRESHOLD, 4, consecutive faulty samples that declare a lane failed (legal range 1..255)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  monitor enable; when low, sample_valid is ignored
sample_valid  input  1  replica_in is valid this cycle
replica_in  input  3*BW_DATA  lane k at bits [BW_DATA*(k+1)-1 -: BW_DATA]
voted_valid  output  1  voted_data valid, one cycle after an accepted sample
voted_data  output  BW_DATA  registered bitwise majority
mismatch_lane  output  3  registered per-lane disagreement flags of the last accepted sample
multi_fault  output  1  last accepted sample had two or more lanes flagged
err_count  output  3*BW_COUNT  per-lane saturating counters, same lane packing as replica_in
lane_failed  output  3  sticky failed flag per lane
irq  output  1  level interrupt
irq_clear  input  1  single-cycle pulse, clears irq
stat_clear  input  1  single-cycle pulse, clears counters, persistence state and lane_failed

Behaviour:
- Reset (async assert, sync release): every output and all internal state are 0; every lane FSM is in OK.
- Accept: accept = enable & sample_valid.
- Majority: maj[b] = majority of the three lanes at bit b.
  - Lane k mismatch m[k] = OR over b of (lane_k[b] ^ maj[b]).
  - mf = (m[0]+m[1]+m[2] >= 2). This is possible when different bits have different faulty lanes.
- Datapath latency is 1 cycle. On an accepting edge:
  - voted_data <= maj, mismatch_lane <= m, multi_fault <= mf, voted_valid <= 1.
- Non-accepting edge: voted_valid <= 0; voted_data, mismatch_lane and multi_fault hold.
- Counters:
  - On an accepting edge with m[k]=1, err_count lane k increments by 1.
  - Saturates at all-ones and does not wrap.
  - Updates on the same edge as mismatch_lane.
- Per-lane FSM (states OK, SUSPECT, FAILED, plus run counter run_k of 8 bits):
  - OK: accept & m[k] -> run_k=1. If PERSIST_THRESHOLD==1 go to FAILED, else go to SUSPECT.
  - SUSPECT:
    - accept & m[k] -> run_k+1. When run_k+1 == PERSIST_THRESHOLD, go to FAILED.
    - accept & !m[k] -> OK, run_k=0.
    - No accept -> hold state and run_k. Idle cycles do not break a run.
  - FAILED: sticky regardless of samples; counters still increment. Left only via stat_clear or rst.
  - lane_failed[k] = (state_k == FAILED), registered, so it is visible the edge the transition occurs.
- irq:
  - Set on an accepting edge where any m[k]=1.
  - Also set on any edge where a lane enters FAILED.
  - Cleared by irq_clear. If set and clear occur on the same edge, set wins (irq stays 1).
- stat_clear:
  - Zeroes err_count and run counters, returns all FSMs to OK, and clears lane_failed.
  - When simultaneous with an accepting sample: clear wins for counters and FSMs (that sample's fault is not counted). The datapath outputs (voted_data, mismatch_lane, multi_fault, voted_valid) still update normally.
  - stat_clear does not affect irq.
- enable low mid-run: treated as no accept; all state holds.
- Input handling: no back-pressure, one sample per cycle sustained throughput. X on replica_in is ignored when not accepted.

Test Plan:
- Reset mid-run: BW_DATA=8, set lane1 FAILED, then assert rst asynchronously between edges -> all outputs 0 immediately, FSMs OK after release.
- Clean samples: lanes all 0xA5, 10 back-to-back accepts -> voted_data=0xA5 one cycle after each, mismatch_lane=000, err_count all 0, irq=0.
- Single-lane fault: lane2=0xA4, lanes0/1=0xA5 for 3 samples, then clean, then 3 faulty again -> voted_data=0xA5, mismatch_lane=100, err_count lane2=6, lane_failed=000 (run broken), irq=1 until irq_clear.
- Persistence with gaps: PERSIST_THRESHOLD=4, lane0 faulty on 4 accepts separated by idle/enable-low cycles -> lane_failed[0]=1 on the 4th accepting edge, irq set that edge.
- Multi-fault and saturation: BW_COUNT=4, lane0 flips bit0 and lane1 flips bit3, for 20 accepts -> mismatch_lane=011, multi_fault=1, err_count lanes0/1=15 (saturated), lane2=0.
- Simultaneous events: irq_clear on the same edge as a faulty accept -> irq stays 1. stat_clear with a faulty accept -> counters 0, FSMs OK, mismatch_lane reflects the sample.
